slink_rx_lane_packer: RTL and testbench



---
 rtl/slink_rx_lane_packer.sv | 133 +++++++++++++
 tb/tb_slink_rx_lane_packer.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/slink_rx_lane_packer.sv
// Packs deskewed reduced-width lane beats into full NUM_LANES*DATA_WIDTH words
// and hands them to the packet parser through a 2-entry valid/ready buffer.
module slink_rx_lane_packer #(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_LANES  = 4
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            enable,
    input  logic [2:0]                      active_lanes,
    input  logic                            flush,
    input  logic [NUM_LANES*DATA_WIDTH-1:0] rx_data_in,
    input  logic                            rx_valid_in,
    output logic [NUM_LANES*DATA_WIDTH-1:0] pk_data,
    output logic                            pk_valid,
    input  logic                            pk_ready,
    output logic [1:0]                      fifo_count,
    output logic                            overflow,
    input  logic                            ovf_clear,
    output logic                            cfg_err
);

    localparam int IDXW = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
    localparam int LOGN = $clog2(NUM_LANES);

    typedef logic [NUM_LANES-1:0][DATA_WIDTH-1:0] word_t;

    word_t           rx_lanes;
    word_t           acc_q, acc_d;
    word_t           buf0_q, buf0_d, buf1_q, buf1_d;
    logic [IDXW-1:0] idx_q, idx_d, idx_eff, last_slot, k;
    logic [1:0]      cnt_q, cnt_d;
    logic            ovf_q, ovf_d, cfg_q, cfg_d;
    logic [2:0]      lsel;
    logic            accept, complete, push, pop, drop;
    int              base, le;

    assign rx_lanes = rx_data_in;

    // Oversized lane encodings are clamped to full width.
    assign lsel      = (active_lanes > 3'(LOGN)) ? 3'(LOGN) : active_lanes;
    assign last_slot = IDXW'((NUM_LANES >> lsel) - 1);
    assign idx_eff   = flush ? '0 : idx_q;
    assign accept    = enable & rx_valid_in;
    assign complete  = (idx_eff == last_slot);
    assign push      = accept & complete;
    assign pop       = (cnt_q != 2'd0) & pk_ready;
    assign drop      = push & ~pop & (cnt_q == 2'd2);

    always_comb begin
        acc_d = acc_q;
        k     = '0;
        le    = 1 << lsel;
        base  = int'(idx_eff) << lsel;
        for (int j = 0; j < NUM_LANES; j++) begin
            if (j >= base && j < base + le) begin
                k        = IDXW'(j - base);
                acc_d[j] = rx_lanes[k];
            end
        end
    end

    always_comb begin
        idx_d = idx_q;
        if (!enable)
            idx_d = '0;
        else if (accept)
            idx_d = complete ? '0 : idx_eff + 1'b1;
        else if (flush)
            idx_d = '0;
    end

    // The pushed word is the merged accumulator so a completing beat lands
    // in the buffer on the same edge it is sampled.
    always_comb begin
        buf0_d = buf0_q;
        buf1_d = buf1_q;
        cnt_d  = cnt_q;
        case (cnt_q)
            2'd0: if (push) begin
                buf0_d = acc_d;
                cnt_d  = 2'd1;
            end
            2'd1: begin
                if (push && pop) begin
                    buf0_d = acc_d;
                end else if (push) begin
                    buf1_d = acc_d;
                    cnt_d  = 2'd2;
                end else if (pop) begin
                    cnt_d  = 2'd0;
                end
            end
            default: begin
                if (pop) begin
                    buf0_d = buf1_q;
                    if (push) buf1_d = acc_d;
                    else      cnt_d  = 2'd1;
                end
            end
        endcase
    end

    assign ovf_d = drop ? 1'b1 : (ovf_clear ? 1'b0 : ovf_q);
    assign cfg_d = (1 << active_lanes) > NUM_LANES;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx_q  <= '0;
            acc_q  <= '0;
            buf0_q <= '0;
            buf1_q <= '0;
            cnt_q  <= 2'd0;
            ovf_q  <= 1'b0;
            cfg_q  <= 1'b0;
        end else begin
            idx_q  <= idx_d;
            if (accept) acc_q <= acc_d;
            buf0_q <= buf0_d;
            buf1_q <= buf1_d;
            cnt_q  <= cnt_d;
            ovf_q  <= ovf_d;
            cfg_q  <= cfg_d;
        end
    end

    assign pk_data    = buf0_q;
    assign pk_valid   = (cnt_q != 2'd0);
    assign fifo_count = cnt_q;
    assign overflow   = ovf_q;
    assign cfg_err    = cfg_q;

endmodule

// File: tb/tb_slink_rx_lane_packer.sv
// Directed bench for slink_rx_lane_packer (NUM_LANES=4, DATA_WIDTH=8):
// inputs change on the falling edge, outputs are sampled on the falling edge.
module tb_slink_rx_lane_packer;

    logic        clk = 1'b0;
    logic        reset, enable, flush, rx_valid_in, pk_ready, ovf_clear;
    logic [2:0]  active_lanes;
    logic [31:0] rx_data_in, pk_data;
    logic        pk_valid, overflow, cfg_err;
    logic [1:0]  fifo_count;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    slink_rx_lane_packer #(.DATA_WIDTH(8), .NUM_LANES(4)) dut (
        .clk(clk), .reset(reset), .enable(enable), .active_lanes(active_lanes),
        .flush(flush), .rx_data_in(rx_data_in), .rx_valid_in(rx_valid_in),
        .pk_data(pk_data), .pk_valid(pk_valid), .pk_ready(pk_ready),
        .fifo_count(fifo_count), .overflow(overflow), .ovf_clear(ovf_clear),
        .cfg_err(cfg_err)
    );

    task automatic set_mode(input logic [2:0] al);
        enable = 1'b0; rx_valid_in = 1'b0; flush = 1'b0;
        active_lanes = al;
        @(negedge clk);
        enable = 1'b1;
    endtask

    task automatic test_reset();
        n_checks++;
        if ({pk_valid, fifo_count, overflow, cfg_err} !== 5'b0 || pk_data !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_state: got valid=%b cnt=%0d ovf=%b cfg=%b data=%h, need all 0",
                     pk_valid, fifo_count, overflow, cfg_err, pk_data);
        end
    endtask

    task automatic test_x4();
        set_mode(3'd2);
        pk_ready = 1'b1;
        rx_valid_in = 1'b1; rx_data_in = 32'h03020100;
        @(negedge clk);
        n_checks++;
        if (pk_valid !== 1'b1 || pk_data !== 32'h03020100) begin
            n_fail++; $display("FAIL x4_word0: got v=%b %h, need v=1 03020100", pk_valid, pk_data);
        end
        rx_data_in = 32'h07060504;
        @(negedge clk);
        n_checks++;
        if (pk_valid !== 1'b1 || pk_data !== 32'h07060504 || fifo_count !== 2'd1) begin
            n_fail++; $display("FAIL x4_word1: got v=%b %h cnt=%0d, need v=1 07060504 cnt=1",
                               pk_valid, pk_data, fifo_count);
        end
        rx_valid_in = 1'b0;
        @(negedge clk);
        n_checks++;
        if (pk_valid !== 1'b0 || fifo_count !== 2'd0 || overflow !== 1'b0) begin
            n_fail++; $display("FAIL x4_drain: got v=%b cnt=%0d ovf=%b, need 0 0 0",
                               pk_valid, fifo_count, overflow);
        end
    endtask

    task automatic test_x1();
        logic [7:0] b;
        set_mode(3'd0);
        pk_ready = 1'b1;
        rx_valid_in = 1'b1;
        for (int i = 0; i < 4; i++) begin
            b = 8'hA0 + 8'(i);
            rx_data_in = {8'hDE, 8'hAD, 8'h5A, b};
            @(negedge clk);
            if (i < 3) begin
                n_checks++;
                if (pk_valid !== 1'b0) begin
                    n_fail++; $display("FAIL x1_early_valid: beat %0d got v=%b, need 0", i, pk_valid);
                end
            end
        end
        rx_valid_in = 1'b0;
        n_checks++;
        if (pk_valid !== 1'b1 || pk_data !== 32'hA3A2A1A0) begin
            n_fail++; $display("FAIL x1_word: got v=%b %h, need v=1 a3a2a1a0", pk_valid, pk_data);
        end
        @(negedge clk);
    endtask

    task automatic test_x2_flush();
        set_mode(3'd1);
        pk_ready = 1'b0;
        // separate flush cycle
        rx_valid_in = 1'b1; rx_data_in = 32'hFFFF1111;
        @(negedge clk);
        rx_valid_in = 1'b0; flush = 1'b1;
        @(negedge clk);
        flush = 1'b0; rx_valid_in = 1'b1; rx_data_in = 32'hEEEE2222;
        @(negedge clk);
        n_checks++;
        if (pk_valid !== 1'b0) begin
            n_fail++; $display("FAIL x2_flush_partial: got v=%b, need 0", pk_valid);
        end
        rx_data_in = 32'hDDDD3333;
        @(negedge clk);
        rx_valid_in = 1'b0;
        n_checks++;
        if (pk_valid !== 1'b1 || pk_data !== 32'h33332222 || fifo_count !== 2'd1) begin
            n_fail++; $display("FAIL x2_flush_sep: got v=%b %h cnt=%0d, need v=1 33332222 cnt=1",
                               pk_valid, pk_data, fifo_count);
        end
        pk_ready = 1'b1;
        @(negedge clk);
        pk_ready = 1'b0;
        // flush coincident with the next beat
        rx_valid_in = 1'b1; rx_data_in = 32'hFFFF1111;
        @(negedge clk);
        flush = 1'b1; rx_data_in = 32'hEEEE2222;
        @(negedge clk);
        flush = 1'b0; rx_data_in = 32'hDDDD3333;
        @(negedge clk);
        rx_valid_in = 1'b0;
        n_checks++;
        if (pk_valid !== 1'b1 || pk_data !== 32'h33332222 || fifo_count !== 2'd1) begin
            n_fail++; $display("FAIL x2_flush_coinc: got v=%b %h cnt=%0d, need v=1 33332222 cnt=1",
                               pk_valid, pk_data, fifo_count);
        end
        pk_ready = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        set_mode(3'd2);
        pk_ready = 1'b0;
        rx_valid_in = 1'b1;
        rx_data_in = 32'hAAAA0001; @(negedge clk);
        rx_data_in = 32'hBBBB0002; @(negedge clk);
        rx_data_in = 32'hCCCC0003; @(negedge clk);
        rx_valid_in = 1'b0;
        n_checks++;
        if (fifo_count !== 2'd2 || overflow !== 1'b1 || pk_data !== 32'hAAAA0001) begin
            n_fail++; $display("FAIL bp_full: got cnt=%0d ovf=%b %h, need 2 1 aaaa0001",
                               fifo_count, overflow, pk_data);
        end
        ovf_clear = 1'b1;
        @(negedge clk);
        ovf_clear = 1'b0;
        n_checks++;
        if (overflow !== 1'b0 || fifo_count !== 2'd2) begin
            n_fail++; $display("FAIL bp_ovf_clear: got ovf=%b cnt=%0d, need 0 2", overflow, fifo_count);
        end
        pk_ready = 1'b1;
        @(negedge clk);
        n_checks++;
        if (pk_data !== 32'hBBBB0002 || fifo_count !== 2'd1) begin
            n_fail++; $display("FAIL bp_order: got %h cnt=%0d, need bbbb0002 1", pk_data, fifo_count);
        end
        @(negedge clk);
        n_checks++;
        if (pk_valid !== 1'b0) begin
            n_fail++; $display("FAIL bp_drain: got v=%b, need 0", pk_valid);
        end
    endtask

    task automatic test_back_to_back();
        pk_ready = 1'b0;
        rx_valid_in = 1'b1;
        rx_data_in = 32'hD0D0D0D0; @(negedge clk);
        rx_data_in = 32'hE0E0E0E0; @(negedge clk);
        pk_ready = 1'b1;
        rx_data_in = 32'hF0F0F0F0; @(negedge clk);
        rx_valid_in = 1'b0;
        n_checks++;
        if (fifo_count !== 2'd2 || overflow !== 1'b0 || pk_data !== 32'hE0E0E0E0) begin
            n_fail++; $display("FAIL full_pushpop: got cnt=%0d ovf=%b %h, need 2 0 e0e0e0e0",
                               fifo_count, overflow, pk_data);
        end
        @(negedge clk);
        n_checks++;
        if (pk_data !== 32'hF0F0F0F0 || fifo_count !== 2'd1) begin
            n_fail++; $display("FAIL full_pushpop_order: got %h cnt=%0d, need f0f0f0f0 1",
                               pk_data, fifo_count);
        end
        @(negedge clk);
    endtask

    task automatic test_cfg_err();
        set_mode(3'd3);
        n_checks++;
        if (cfg_err !== 1'b1) begin
            n_fail++; $display("FAIL cfg_err_flag: got %b, need 1", cfg_err);
        end
        pk_ready = 1'b1;
        rx_valid_in = 1'b1; rx_data_in = 32'h44332211;
        @(negedge clk);
        rx_valid_in = 1'b0;
        n_checks++;
        if (pk_valid !== 1'b1 || pk_data !== 32'h44332211) begin
            n_fail++; $display("FAIL cfg_err_clamp: got v=%b %h, need v=1 44332211", pk_valid, pk_data);
        end
        @(negedge clk);
    endtask

    task automatic test_async_reset();
        logic [7:0] b;
        set_mode(3'd2);
        pk_ready = 1'b0;
        rx_valid_in = 1'b1; rx_data_in = 32'h55555555;
        @(negedge clk);
        rx_valid_in = 1'b0;
        set_mode(3'd0);
        rx_valid_in = 1'b1;
        rx_data_in = 32'h000000B0; @(negedge clk);
        rx_data_in = 32'h000000B1; @(negedge clk);
        rx_valid_in = 1'b0;
        #2 reset = 1'b1;
        #1;
        n_checks++;
        if (pk_valid !== 1'b0 || fifo_count !== 2'd0 || pk_data !== 32'h0 || cfg_err !== 1'b0) begin
            n_fail++; $display("FAIL async_reset: got v=%b cnt=%0d %h cfg=%b, need all 0",
                               pk_valid, fifo_count, pk_data, cfg_err);
        end
        @(negedge clk);
        reset = 1'b0;
        rx_valid_in = 1'b1;
        for (int i = 0; i < 4; i++) begin
            b = 8'hC0 + 8'(i);
            rx_data_in = {24'h0, b};
            @(negedge clk);
        end
        rx_valid_in = 1'b0;
        n_checks++;
        if (pk_valid !== 1'b1 || pk_data !== 32'hC3C2C1C0 || fifo_count !== 2'd1) begin
            n_fail++; $display("FAIL reset_slot0: got v=%b %h cnt=%0d, need v=1 c3c2c1c0 cnt=1",
                               pk_valid, pk_data, fifo_count);
        end
    endtask

    initial begin
        reset = 1'b1; enable = 1'b0; flush = 1'b0; rx_valid_in = 1'b0;
        pk_ready = 1'b0; ovf_clear = 1'b0; active_lanes = 3'd2; rx_data_in = '0;
        #1;
        test_reset();
        @(negedge clk); @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        test_reset();
        test_x4();
        test_x1();
        test_x2_flush();
        test_backpressure();
        test_back_to_back();
        test_cfg_err();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
